// File: rtl/vga_timing_cfg.sv
// Runtime-configurable VGA timing generator: counters, sync, blanking, DE and strobes, all registered.
// New timing is staged in a shadow set and switched in only at the frame wrap so a mode change never tears.
module vga_timing_cfg #(
   parameter int   CNT_W      = 11,
   parameter logic H_SYNC_POL = 1'b1,
   parameter logic V_SYNC_POL = 1'b1,
   parameter int   H_ACT_D    = 800,
   parameter int   H_SS_D     = 840,
   parameter int   H_SL_D     = 128,
   parameter int   H_TOT_D    = 1056,
   parameter int   V_ACT_D    = 600,
   parameter int   V_SS_D     = 601,
   parameter int   V_SL_D     = 4,
   parameter int   V_TOT_D    = 628
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_h_act,
   input  logic [CNT_W-1:0] cfg_h_ss,
   input  logic [CNT_W-1:0] cfg_h_sl,
   input  logic [CNT_W-1:0] cfg_h_tot,
   input  logic [CNT_W-1:0] cfg_v_act,
   input  logic [CNT_W-1:0] cfg_v_ss,
   input  logic [CNT_W-1:0] cfg_v_sl,
   input  logic [CNT_W-1:0] cfg_v_tot,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             de,
   output logic             line_start,
   output logic             frame_start,
   output logic             cfg_pending,
   output logic             cfg_err
);

   typedef struct packed {
      logic [CNT_W-1:0] h_act;
      logic [CNT_W-1:0] h_ss;
      logic [CNT_W-1:0] h_sl;
      logic [CNT_W-1:0] h_tot;
      logic [CNT_W-1:0] v_act;
      logic [CNT_W-1:0] v_ss;
      logic [CNT_W-1:0] v_sl;
      logic [CNT_W-1:0] v_tot;
   } tim_t;

   localparam tim_t DEF_SET = '{
      h_act: CNT_W'(H_ACT_D), h_ss: CNT_W'(H_SS_D), h_sl: CNT_W'(H_SL_D), h_tot: CNT_W'(H_TOT_D),
      v_act: CNT_W'(V_ACT_D), v_ss: CNT_W'(V_SS_D), v_sl: CNT_W'(V_SL_D), v_tot: CNT_W'(V_TOT_D)
   };

   tim_t             act_q;
   tim_t             shd_q;
   tim_t             act_nx;
   tim_t             cfg_in;
   logic [CNT_W-1:0] h_nx;
   logic [CNT_W-1:0] v_nx;
   logic             wrap;
   logic             apply;
   logic             cfg_ok;
   logic             hs_on;
   logic             vs_on;
   logic [CNT_W:0]   h_end_cfg;
   logic [CNT_W:0]   v_end_cfg;
   logic [CNT_W:0]   hs_end;
   logic [CNT_W:0]   vs_end;

   assign cfg_in = '{
      h_act: cfg_h_act, h_ss: cfg_h_ss, h_sl: cfg_h_sl, h_tot: cfg_h_tot,
      v_act: cfg_v_act, v_ss: cfg_v_ss, v_sl: cfg_v_sl, v_tot: cfg_v_tot
   };

   // Next position and the timing set it will be judged against; outputs are derived from these
   // so that every registered output matches the registered position.
   always_comb begin
      h_nx = hcount;
      v_nx = vcount;
      wrap = 1'b0;
      if (ce) begin
         if (hcount == act_q.h_tot - 1'b1) begin
            h_nx = '0;
            if (vcount == act_q.v_tot - 1'b1) begin
               v_nx = '0;
               wrap = 1'b1;
            end else begin
               v_nx = vcount + 1'b1;
            end
         end else begin
            h_nx = hcount + 1'b1;
         end
      end
      apply  = wrap & cfg_pending;
      act_nx = apply ? shd_q : act_q;
   end

   // Sums carry one extra bit so ss+sl cannot wrap; tot always fits the field, so no upper check.
   always_comb begin
      h_end_cfg = {1'b0, cfg_h_ss} + {1'b0, cfg_h_sl};
      v_end_cfg = {1'b0, cfg_v_ss} + {1'b0, cfg_v_sl};
      cfg_ok    = (cfg_h_act != '0) && (cfg_h_act < cfg_h_ss) && (cfg_h_sl != '0) &&
                  (h_end_cfg <= {1'b0, cfg_h_tot}) &&
                  (cfg_v_act != '0) && (cfg_v_act < cfg_v_ss) && (cfg_v_sl != '0) &&
                  (v_end_cfg <= {1'b0, cfg_v_tot});
   end

   always_comb begin
      hs_end = {1'b0, act_nx.h_ss} + {1'b0, act_nx.h_sl};
      vs_end = {1'b0, act_nx.v_ss} + {1'b0, act_nx.v_sl};
      hs_on  = ({1'b0, h_nx} >= {1'b0, act_nx.h_ss}) && ({1'b0, h_nx} < hs_end);
      vs_on  = ({1'b0, v_nx} >= {1'b0, act_nx.v_ss}) && ({1'b0, v_nx} < vs_end);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q       <= DEF_SET;
         shd_q       <= DEF_SET;
         hcount      <= CNT_W'(H_TOT_D - 1);
         vcount      <= CNT_W'(V_TOT_D - 1);
         hsync       <= ~H_SYNC_POL;
         vsync       <= ~V_SYNC_POL;
         hblnk       <= 1'b1;
         vblnk       <= 1'b1;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         act_q       <= act_nx;
         hcount      <= h_nx;
         vcount      <= v_nx;
         hsync       <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
         vsync       <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
         hblnk       <= (h_nx >= act_nx.h_act);
         vblnk       <= (v_nx >= act_nx.v_act);
         de          <= (h_nx < act_nx.h_act) && (v_nx < act_nx.v_act);
         line_start  <= (h_nx == '0);
         frame_start <= (h_nx == '0) && (v_nx == '0);
         cfg_err     <= cfg_valid & ~cfg_ok;
         // A load in the wrap cycle re-arms pending after the old shadow has just been applied.
         if (cfg_valid && cfg_ok) begin
            shd_q       <= cfg_in;
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

endmodule
